// File: rtl/expr_parse_cc.sv
// expr_parse_cc: infix token front end of the stack calculator; feeds operand/operator stacks and
// sequences reductions through calc_start/calc_complete. Define EXPR_PARSE_ERR_CHK_EN for sticky paren errors.
module expr_parse_cc #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tok_valid,
    output logic              o_tok_ready,
    input  logic [1:0]        i_tok_type,
    input  logic [3:0]        i_tok_val,
    output logic [DATA_W-1:0] o_opnd_data,
    output logic              o_opndSTK_push,
    output logic [2:0]        o_op_code,
    output logic              o_opSTK_push,
    output logic              o_opSTK_pop,
    input  logic [2:0]        i_op_top,
    input  logic              i_op_empty,
    output logic              o_calc_start,
    input  logic              i_calc_complete,
    output logic              o_done,
    output logic              o_err
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_NUM,
        S_EVAL,
        S_START,
        S_WAIT,
        S_PUSH_OP,
        S_POP_LP,
        S_DONE
`ifdef EXPR_PARSE_ERR_CHK_EN
        , S_ERR
`endif
    } state_t;

    localparam logic [1:0] T_DIGIT = 2'd0;
    localparam logic [1:0] T_OP    = 2'd1;
    localparam logic [1:0] T_PAREN = 2'd2;
    localparam logic [1:0] T_END   = 2'd3;
    localparam logic [2:0] OP_LP   = 3'd4;

`ifdef EXPR_PARSE_ERR_CHK_EN
    localparam state_t S_RPAREN_BAD = S_ERR;
    localparam state_t S_END_LP     = S_ERR;
`else
    // without checking, a stray ')' is dropped and a dangling '(' is popped before finishing
    localparam state_t S_RPAREN_BAD = S_IDLE;
    localparam state_t S_END_LP     = S_POP_LP;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_acc;
    logic              r_num_pending;
    logic [1:0]        r_tok_type;
    logic [1:0]        r_tok_val;
    logic              w_accept;
    logic              w_top_lp;
    logic              w_top_op;
    logic              w_reduce_op;

    assign w_accept = (r_state == S_IDLE) && i_tok_valid;
    assign w_top_lp = !i_op_empty && (i_op_top == OP_LP);
    assign w_top_op = !i_op_empty && (i_op_top != OP_LP);
    // code bit 1 marks * and /, i.e. the high precedence level
    assign w_reduce_op = w_top_op && (i_op_top[1] || !r_tok_val[1]);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_num_pending <= 1'b0;
            r_tok_type    <= '0;
            r_tok_val     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_tok_type <= i_tok_type;
                r_tok_val  <= i_tok_val[1:0];
                if (i_tok_type == T_DIGIT) begin
                    r_acc         <= r_acc * DATA_W'(10) + DATA_W'(i_tok_val);
                    r_num_pending <= 1'b1;
                end
            end
            if (r_state == S_PUSH_NUM) begin
                r_acc         <= '0;
                r_num_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (i_tok_type != T_DIGIT))
                    w_next = r_num_pending ? S_PUSH_NUM : S_EVAL;
            end
            S_PUSH_NUM: w_next = S_EVAL;
            S_EVAL: begin
                case (r_tok_type)
                    T_DIGIT: w_next = S_IDLE;
                    T_OP:    w_next = w_reduce_op ? S_START : S_PUSH_OP;
                    T_PAREN: begin
                        if (!r_tok_val[0])
                            w_next = S_PUSH_OP;
                        else if (w_top_op)
                            w_next = S_START;
                        else if (w_top_lp)
                            w_next = S_POP_LP;
                        else
                            w_next = S_RPAREN_BAD;
                    end
                    T_END: begin
                        if (w_top_op)
                            w_next = S_START;
                        else if (w_top_lp)
                            w_next = S_END_LP;
                        else
                            w_next = S_DONE;
                    end
                endcase
            end
            S_START:   w_next = S_WAIT;
            S_WAIT:    if (i_calc_complete) w_next = S_EVAL;
            S_PUSH_OP: w_next = S_IDLE;
            // an end marker keeps reducing once its '(' is gone
            S_POP_LP:  w_next = (r_tok_type == T_END) ? S_EVAL : S_IDLE;
            S_DONE:    w_next = S_IDLE;
`ifdef EXPR_PARSE_ERR_CHK_EN
            S_ERR:     w_next = S_ERR;
`endif
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tok_ready    = (r_state == S_IDLE);
        o_opndSTK_push = (r_state == S_PUSH_NUM);
        o_opSTK_push   = (r_state == S_PUSH_OP);
        o_opSTK_pop    = (r_state == S_POP_LP);
        o_calc_start   = (r_state == S_START);
        o_done         = (r_state == S_DONE);
        o_op_code      = '0;
        if (r_state == S_PUSH_OP)
            o_op_code = (r_tok_type == T_PAREN) ? OP_LP : {1'b0, r_tok_val};
    end

    assign o_opnd_data = r_acc;

`ifdef EXPR_PARSE_ERR_CHK_EN
    assign o_err = (r_state == S_ERR);
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_expr_parse_cc.sv
// tb_expr_parse_cc: models the operand/operator stacks and calc stage around expr_parse_cc and
// compares results against arithmetic evaluation of the token string.
module tb_expr_parse_cc;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        tok_valid = 1'b0;
    logic [1:0]  tok_type = 2'd0;
    logic [3:0]  tok_val = 4'd0;
    logic        tok_ready, opnd_push, op_push, op_pop, calc_start, done, err;
    logic [15:0] opnd_data;
    logic [2:0]  op_code, op_top;
    logic        op_empty;
    logic        calc_complete = 1'b0;

    logic        t8_valid = 1'b0;
    logic [1:0]  t8_type = 2'd0;
    logic [3:0]  t8_val = 4'd0;
    logic        t8_ready, t8_opnd_push, t8_op_push, t8_op_pop, t8_calc_start, t8_done, t8_err;
    logic [7:0]  t8_data;
    logic [2:0]  t8_op_code;
    logic [2:0]  t8_top = 3'd0;
    logic        t8_empty = 1'b1;
    logic        t8_cc = 1'b0;

    expr_parse_cc #(.DATA_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_tok_valid(tok_valid), .o_tok_ready(tok_ready),
        .i_tok_type(tok_type), .i_tok_val(tok_val), .o_opnd_data(opnd_data),
        .o_opndSTK_push(opnd_push), .o_op_code(op_code), .o_opSTK_push(op_push),
        .o_opSTK_pop(op_pop), .i_op_top(op_top), .i_op_empty(op_empty),
        .o_calc_start(calc_start), .i_calc_complete(calc_complete), .o_done(done), .o_err(err)
    );

    expr_parse_cc #(.DATA_W(8)) dut8 (
        .i_clk(clk), .i_reset(reset), .i_tok_valid(t8_valid), .o_tok_ready(t8_ready),
        .i_tok_type(t8_type), .i_tok_val(t8_val), .o_opnd_data(t8_data),
        .o_opndSTK_push(t8_opnd_push), .o_op_code(t8_op_code), .o_opSTK_push(t8_op_push),
        .o_opSTK_pop(t8_op_pop), .i_op_top(t8_top), .i_op_empty(t8_empty),
        .o_calc_start(t8_calc_start), .i_calc_complete(t8_cc), .o_done(t8_done), .o_err(t8_err)
    );

    int total = 0;
    int bad = 0;

    // stack and calc-stage model, updated mid-cycle so the DUT sees stable inputs at each rising edge
    logic [2:0]  op_stk [0:63];
    logic [15:0] nd_stk [0:63];
    int op_sp = 0, nd_sp = 0;
    int busy = 0, cnt = 0, fixed_lat = 0;
    int n_start = 0, n_done = 0, n_opnd = 0, n_opush = 0, n_pop = 0, op_seq = 0, first_opnd = -1, viol = 0;
    logic mdl_clr = 1'b1;

    assign op_empty = (op_sp == 0);
    assign op_top   = (op_sp > 0) ? op_stk[op_sp[5:0] - 6'd1] : 3'd0;

    always @(negedge clk) begin
        logic [15:0] a, b, r;
        logic [2:0]  op;
        if (mdl_clr) begin
            op_sp = 0; nd_sp = 0; busy = 0; cnt = 0; calc_complete = 1'b0;
            n_start = 0; n_done = 0; n_opnd = 0; n_opush = 0; n_pop = 0;
            op_seq = 0; first_opnd = -1; viol = 0;
        end else begin
            calc_complete = 1'b0;
            if (opnd_push) begin
                if (n_opnd == 0) first_opnd = int'(opnd_data);
                n_opnd++;
                if (nd_sp < 64) begin nd_stk[nd_sp[5:0]] = opnd_data; nd_sp++; end
                else viol++;
            end
            if (op_push) begin
                n_opush++;
                op_seq = op_seq * 8 + int'(op_code) + 1;
                if (op_sp < 64) begin op_stk[op_sp[5:0]] = op_code; op_sp++; end
                else viol++;
            end
            if (op_pop) begin
                n_pop++;
                if (op_sp == 0 || op_stk[op_sp[5:0] - 6'd1] != 3'd4) viol++;
                if (op_sp > 0) op_sp--;
            end
            if (done) n_done++;
            if (busy != 0) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    calc_complete = 1'b1;
                    if (op_sp < 1 || nd_sp < 2) viol++;
                    else begin
                        op = op_stk[op_sp[5:0] - 6'd1];
                        op_sp--;
                        b = nd_stk[nd_sp[5:0] - 6'd1];
                        a = nd_stk[nd_sp[5:0] - 6'd2];
                        nd_sp -= 2;
                        case (op)
                            3'd0: r = a + b;
                            3'd1: r = a - b;
                            3'd2: r = a * b;
                            3'd3: r = (b == 16'd0) ? 16'd0 : a / b;
                            default: begin r = 16'd0; viol++; end
                        endcase
                        nd_stk[nd_sp[5:0]] = r;
                        nd_sp++;
                    end
                end
            end
            if (calc_start) begin
                if (busy != 0) viol++;
                n_start++;
                busy = 1;
                cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            end
        end
    end

    typedef struct {
        string expr;
        int    val;
        int    starts;
        int    pre_end;
        int    nopnd;
        int    opseq;
        int    pops;
        int    first;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input string e, input int v, input int st, input int pe, input int no,
                           input int os, input int po, input int fi);
        vec_t t;
        t.expr = e; t.val = v; t.starts = st; t.pre_end = pe;
        t.nopnd = no; t.opseq = os; t.pops = po; t.first = fi;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int top_val();
        return (nd_sp == 1) ? int'(nd_stk[0]) : -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mdl_clr = 1'b1; tok_valid = 1'b0; t8_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; mdl_clr = 1'b0;
    endtask

    task automatic send_tok(input logic [1:0] ty, input logic [3:0] v);
        int k = 0;
        @(negedge clk);
        tok_valid = 1'b1; tok_type = ty; tok_val = v;
        while (!tok_ready && k < 300) begin @(negedge clk); k++; end
        if (!tok_ready) begin
            total++; bad++;
            $display("FAIL token accept timeout: ready=%0b required 1", tok_ready);
        end
        @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask

    task automatic busy_cycles(output int n);
        int k = 0;
        @(negedge clk);
        while (!tok_ready && k < 100) begin k++; @(negedge clk); end
        n = k + 1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done == 0 && k < 3000) begin @(negedge clk); k++; end
        if (n_done == 0) begin
            total++; bad++;
            $display("FAIL done timeout: done count=%0d required 1", n_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_expr(input string s, output int pre_end);
        int k;
        pre_end = -1;
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            logic [1:0] ty;
            logic [3:0] v;
            c = s[i];
            ty = 2'd3; v = 4'd0;
            if (c >= "0" && c <= "9") begin ty = 2'd0; v = 4'(c - "0"); end
            else if (c == "+") begin ty = 2'd1; v = 4'd0; end
            else if (c == "-") begin ty = 2'd1; v = 4'd1; end
            else if (c == "*") begin ty = 2'd1; v = 4'd2; end
            else if (c == "/") begin ty = 2'd1; v = 4'd3; end
            else if (c == "(") begin ty = 2'd2; v = 4'd0; end
            else if (c == ")") begin ty = 2'd2; v = 4'd1; end
            if (ty == 2'd3) begin
                k = 0;
                while (!tok_ready && k < 300) begin @(negedge clk); k++; end
                pre_end = n_start;
            end
            send_tok(ty, v);
        end
        wait_done();
    endtask

    // builds a random sum of products, some factors parenthesised, and evaluates it directly
    task automatic gen_expr(output string s, output int val, output int nops, output int nnum, output int npar);
        logic [15:0] sum, term, f, a, b;
        string s_t, s_f;
        int nterms, nf, pm, md;
        s = ""; nops = 0; nnum = 0; npar = 0; sum = 16'd0;
        nterms = int'($urandom_range(1, 3));
        for (int t = 0; t < nterms; t++) begin
            nf = int'($urandom_range(1, 3));
            term = 16'd0; s_t = "";
            for (int j = 0; j < nf; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = 16'($urandom_range(0, 99));
                    b = 16'($urandom_range(0, 99));
                    pm = int'($urandom_range(0, 1));
                    f = (pm != 0) ? a - b : a + b;
                    s_f = $sformatf("(%0d%s%0d)", a, (pm != 0) ? "-" : "+", b);
                    nops++; nnum += 2; npar++;
                end else begin
                    f = 16'($urandom_range(0, 999));
                    s_f = $sformatf("%0d", f);
                    nnum++;
                end
                if (j == 0) begin
                    term = f; s_t = s_f;
                end else begin
                    md = int'($urandom_range(0, 1));
                    term = (md != 0) ? ((f == 16'd0) ? 16'd0 : term / f) : term * f;
                    s_t = $sformatf("%s%s%s", s_t, (md != 0) ? "/" : "*", s_f);
                    nops++;
                end
            end
            if (t == 0) begin
                sum = term; s = s_t;
            end else begin
                pm = int'($urandom_range(0, 1));
                sum = (pm != 0) ? sum - term : sum + term;
                s = $sformatf("%s%s%s", s, (pm != 0) ? "-" : "+", s_t);
                nops++;
            end
        end
        s = {s, "="};
        val = int'(sum);
    endtask

    initial begin
        int pe, n, got8, done8, flag;
        string s;
        int ev, eo, en, ep;

        add_vec("12+3=",        15,    1, 0, 2, 1,     0, 12);
        add_vec("2+3*4=",       14,    2, 0, 3, 11,    0, 2);
        add_vec("8-3-1=",       4,     2, 1, 3, 18,    0, 8);
        add_vec("(2+3)*4=",     20,    2, 1, 3, 331,   1, 2);
        add_vec("7=",           7,     0, 0, 1, 0,     0, 7);
        add_vec("((5))=",       5,     0, 0, 1, 45,    2, 5);
        add_vec("100/7-2*3=",   8,     3, 1, 4, 275,   0, 100);
        add_vec("9*(8-6)/3+1=", 7,     4, 3, 5, 15009, 1, 9);
        add_vec("1-5=",         65532, 1, 0, 2, 2,     0, 1);
        add_vec("6/0+2*3-4=",   2,     4, 3, 5, 2138,  0, 6);

        #12;
        chk("reset outputs",
            int'({tok_ready, opnd_push, op_push, op_pop, calc_start, done, err, opnd_data, op_code}),
            int'({1'b1, 6'b0, 16'd0, 3'd0}));
        chk("reset outputs w8", int'({t8_ready, t8_opnd_push, t8_done, t8_data}), int'({1'b1, 2'b0, 8'd0}));

        foreach (vq[i]) begin
            do_reset();
            run_expr(vq[i].expr, pe);
            chk({vq[i].expr, " value"}, top_val(), vq[i].val);
            chk({vq[i].expr, " depths"}, nd_sp * 100 + op_sp, 100);
            chk({vq[i].expr, " calc_start total"}, n_start, vq[i].starts);
            chk({vq[i].expr, " calc_start before end"}, pe, vq[i].pre_end);
            chk({vq[i].expr, " operand pushes"}, n_opnd, vq[i].nopnd);
            chk({vq[i].expr, " op push order"}, op_seq, vq[i].opseq);
            chk({vq[i].expr, " op pops"}, n_pop, vq[i].pops);
            chk({vq[i].expr, " first operand"}, first_opnd, vq[i].first);
            chk({vq[i].expr, " done pulses"}, n_done, 1);
            chk({vq[i].expr, " protocol"}, viol, 0);
        end

        // handshake timing: token occupancy in cycles including the accept cycle
        do_reset();
        send_tok(2'd2, 4'd0);
        busy_cycles(n);
        chk("lparen occupancy", n, 3);
        send_tok(2'd0, 4'd5);
        chk("digit keeps ready", int'(tok_ready), 1);
        send_tok(2'd1, 4'd0);
        busy_cycles(n);
        chk("op after number occupancy", n, 4);
        send_tok(2'd0, 4'd3);
        send_tok(2'd2, 4'd1);
        send_tok(2'd3, 4'd0);
        wait_done();
        chk("(5+3) value", top_val(), 8);
        chk("(5+3) calc_start", n_start, 1);

        // narrow accumulator wraps modulo 2^8
        do_reset();
        got8 = -1; done8 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            t8_valid = 1'b1;
            t8_type = (i == 3) ? 2'd3 : 2'd0;
            t8_val = (i == 0) ? 4'd3 : 4'd0;
            @(posedge clk);
            #1 t8_valid = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (t8_opnd_push) got8 = int'(t8_data);
            if (t8_done) done8++;
        end
        chk("w8 300 mod 256", got8, 44);
        chk("w8 done", done8, 1);

        // reset while waiting on the calc stage; its late completion must be ignored
        do_reset();
        fixed_lat = 8;
        send_tok(2'd0, 4'd1);
        send_tok(2'd1, 4'd0);
        send_tok(2'd0, 4'd2);
        send_tok(2'd3, 4'd0);
        n = 0;
        while (n_start == 0 && n < 100) begin @(negedge clk); n++; end
        chk("wait entry calc_start", n_start, 1);
        @(negedge clk);
        @(negedge clk);
        chk("in wait ready", int'({tok_ready, calc_start}), 0);
        reset = 1'b1;
        #1;
        chk("reset in wait outputs",
            int'({tok_ready, opnd_push, op_push, op_pop, calc_start, done, err, opnd_data, op_code}),
            int'({1'b1, 6'b0, 16'd0, 3'd0}));
        @(negedge clk);
        reset = 1'b0;
        flag = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!tok_ready || calc_start || opnd_push || op_push || op_pop || done) flag++;
        end
        chk("late calc_complete ignored", flag, 0);
        fixed_lat = 0;

        // stray ')' on an empty stack
        do_reset();
        send_tok(2'd2, 4'd1);
        repeat (6) @(negedge clk);
`ifdef EXPR_PARSE_ERR_CHK_EN
        chk("stray rparen err/ready", int'({err, tok_ready}), 2);
        repeat (10) @(negedge clk);
        chk("stray rparen sticky", int'({err, tok_ready}), 2);
        do_reset();
        chk("err cleared by reset", int'({err, tok_ready}), 1);
`else
        chk("stray rparen err/ready", int'({err, tok_ready}), 1);
        chk("stray rparen no activity", n_opnd + n_opush + n_start + n_pop, 0);
`endif

        // end marker with '(' on top
        do_reset();
`ifdef EXPR_PARSE_ERR_CHK_EN
        send_tok(2'd2, 4'd0);
        send_tok(2'd0, 4'd5);
        send_tok(2'd3, 4'd0);
        repeat (10) @(negedge clk);
        chk("end on lparen err/ready", int'({err, tok_ready}), 2);
        chk("end on lparen no done", n_done, 0);
`else
        run_expr("(5=", pe);
        chk("end on lparen value", top_val(), 5);
        chk("end on lparen pops", n_pop, 1);
        chk("end on lparen done", n_done, 1);
        chk("end on lparen err", int'(err), 0);
`endif

        for (int r = 0; r < 40; r++) begin
            gen_expr(s, ev, eo, en, ep);
            do_reset();
            run_expr(s, pe);
            chk({"rnd ", s, " value"}, top_val(), ev);
            chk({"rnd ", s, " calc_start"}, n_start, eo);
            chk({"rnd ", s, " operand pushes"}, n_opnd, en);
            chk({"rnd ", s, " pops"}, n_pop, ep);
            chk({"rnd ", s, " done"}, n_done, 1);
            chk({"rnd ", s, " protocol"}, viol, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
